// File: rtl/cosine_arbiter.sv
// Two-requester arbiter in front of a single shared cosine engine.
// Round-robin on ties, engine launch/hold/wait sequencing, sticky timeout error.
module cosine_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] x0,
    input  logic [9:0] x1,
    input  logic [7:0] y0,
    input  logic [7:0] y1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic [9:0] res0,
    output logic [9:0] res1,
    output logic       eng_start,
    output logic [9:0] eng_x,
    output logic [7:0] eng_y,
    input  logic       eng_ready,
    input  logic [9:0] eng_result,
    output logic       err
);

    // state  | meaning
    // IDLE   | waiting for a request while the engine reports ready
    // LAUNCH | start pulse and ack to the owner
    // HOLD   | engine drops ready here, so ready is ignored; counter cleared
    // WAIT   | waiting for engine result, bounded by TIMEOUT cycles
    typedef enum logic [1:0] {IDLE, LAUNCH, HOLD, WAIT} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        owner;
    logic        last;
    logic [15:0] cnt;
    logic        pick;

    // last=1 after reset so requester 0 wins the first tie
    always_comb begin
        pick = 1'b0;
        if (req0 && req1)
            pick = ~last;
        else if (req1)
            pick = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            eng_start <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            res0      <= '0;
            res1      <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            err       <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            case (state)
                IDLE: begin
                    if (eng_ready && (req0 || req1)) begin
                        owner     <= pick;
                        eng_x     <= pick ? x1 : x0;
                        eng_y     <= pick ? y1 : y0;
                        eng_start <= 1'b1;
                        ack0      <= ~pick;
                        ack1      <= pick;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: state <= HOLD;
                HOLD: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_ready) begin
                        if (owner) begin
                            res1  <= eng_result;
                            done1 <= 1'b1;
                        end else begin
                            res0  <= eng_result;
                            done0 <= 1'b1;
                        end
                        last  <= owner;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt == CNT_LAST) begin
                            err   <= 1'b1;
                            last  <= owner;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_arbiter.sv
// Directed bench for cosine_arbiter: behavioural engine model on the main
// instance, a second instance with TIMEOUT=16 and a hand-driven ready line.
module tb_cosine_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [9:0] x0 = '0, x1 = '0;
    logic [7:0] y0 = '0, y1 = '0;
    logic       ack0, ack1, done0, done1, eng_start, err;
    logic [9:0] res0, res1, eng_x, eng_result;
    logic [7:0] eng_y;
    logic       eng_ready;

    logic       t_req0 = 1'b0, t_req1 = 1'b0, t_rdy = 1'b0;
    logic       t_ack0, t_ack1, t_done0, t_done1, t_start, t_err;
    logic [9:0] t_res0, t_res1, t_ex;
    logic [7:0] t_ey;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cosine_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1), .eng_start(eng_start),
        .eng_x(eng_x), .eng_y(eng_y), .eng_ready(eng_ready),
        .eng_result(eng_result), .err(err)
    );

    cosine_arbiter #(.TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .req0(t_req0), .req1(t_req1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .ack0(t_ack0), .ack1(t_ack1), .done0(t_done0), .done1(t_done1),
        .res0(t_res0), .res1(t_res1), .eng_start(t_start),
        .eng_x(t_ex), .eng_y(t_ey), .eng_ready(t_rdy),
        .eng_result(10'h3FF), .err(t_err)
    );

    // Engine model: drops ready on start, result = x + y unless overridden
    logic       m_ready = 1'b1;
    int         m_cnt = 0;
    int         m_lat = 20;
    logic [9:0] m_res = '0;
    logic       m_use_ovr = 1'b0;
    logic [9:0] m_ovr = '0;
    logic       m_force = 1'b0;

    always @(posedge clk) begin
        if (eng_start) begin
            m_ready <= 1'b0;
            m_cnt   <= m_lat - 1;
            m_res   <= m_use_ovr ? m_ovr : eng_x + {2'b00, eng_y};
        end else if (!m_ready) begin
            if (m_cnt == 0) m_ready <= 1'b1;
            else            m_cnt   <= m_cnt - 1;
        end
    end

    assign eng_ready  = m_ready & ~m_force;
    assign eng_result = m_res;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input int max, output bit ok);
        int n = 0;
        while (!(ack0 || ack1) && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = ack0 || ack1;
    endtask

    task automatic wait_done(input int max, output bit ok);
        int n = 0;
        while (!(done0 || done1) && n < max) begin
            @(negedge clk);
            n++;
        end
        ok = done0 || done1;
    endtask

    logic [63:0] all_out;
    assign all_out = {eng_start, ack0, ack1, done0, done1, res0, res1, eng_x, eng_y, err,
                      t_start, t_ack0, t_ack1, t_done0, t_done1, t_res0, t_res1, t_err};

    initial begin
        bit ok;
        bit seen;
        int cnt_done;

        // reset with random inputs
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {req0, req1, t_req0, t_req1, t_rdy} = 5'($urandom);
            x0 = 10'($urandom); x1 = 10'($urandom);
            y0 = 8'($urandom);  y1 = 8'($urandom);
            #1 chk("rst_outputs_zero", all_out, 64'd0);
        end
        req0 = 0; req1 = 0; t_req0 = 0; t_req1 = 0; t_rdy = 0;
        rst = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= ack0 | ack1 | eng_start;
        end
        chk("rst_no_ack_without_req", seen, 0);

        // single request
        do_reset();
        m_lat = 20; m_use_ovr = 1'b1; m_ovr = 10'h2A5;
        x0 = 10'h100; y0 = 8'h40; req0 = 1'b1;
        wait_ack(10, ok);
        chk("single_ack_timeout", ok, 1);
        chk("single_ack0", {ack0, ack1, eng_start}, 3'b101);
        chk("single_eng_x", eng_x, 10'h100);
        chk("single_eng_y", eng_y, 8'h40);
        req0 = 1'b0;
        @(negedge clk);
        chk("single_pulse_width", {ack0, eng_start}, 2'b00);
        wait_done(40, ok);
        chk("single_done_timeout", ok, 1);
        chk("single_done0", {done0, done1}, 2'b10);
        chk("single_res0", res0, 10'h2A5);
        chk("single_res1", res1, 10'h000);
        cnt_done = 0;
        repeat (10) begin
            @(negedge clk);
            cnt_done += int'(done0) + int'(done1);
        end
        chk("single_one_done", cnt_done, 0);
        m_use_ovr = 1'b0;

        // contention: both held high, latency 5
        do_reset();
        m_lat = 5;
        x0 = 10'h0A0; y0 = 8'h05; x1 = 10'h155; y1 = 8'h10;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(20, ok);
            chk("cont_ack_timeout", ok, 1);
            chk("cont_grant_order", {ack1, ack0}, (k % 2) ? 2'b10 : 2'b01);
            wait_done(20, ok);
            chk("cont_done_timeout", ok, 1);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            if (k % 2) begin
                chk("cont_done1", {done1, done0}, 2'b10);
                chk("cont_res1", res1, 10'h165);
                chk("cont_res0_kept", res0, 10'h0A5);
            end else begin
                chk("cont_done0", {done1, done0}, 2'b01);
                chk("cont_res0", res0, 10'h0A5);
            end
            @(negedge clk);
        end

        // timeout on the TIMEOUT=16 instance
        do_reset();
        t_rdy = 1'b1; t_req0 = 1'b1;
        begin
            int n = 0;
            while (!t_ack0 && n < 10) begin @(negedge clk); n++; end
        end
        chk("to_grant", t_ack0, 1);
        t_req0 = 1'b0; t_rdy = 1'b0;
        @(negedge clk);
        seen = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            seen |= t_done0 | t_done1;
            if (i == 16) chk("to_err_early", t_err, 0);
        end
        @(negedge clk);
        seen |= t_done0 | t_done1;
        chk("to_err_set", t_err, 1);
        chk("to_no_done", seen, 0);
        chk("to_res0_kept", t_res0, 10'h000);
        t_req1 = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= t_ack1;
        end
        chk("to_no_grant_busy", seen, 0);
        t_rdy = 1'b1;
        @(negedge clk);
        chk("to_ack1", {t_ack1, t_ack0}, 2'b10);
        t_req1 = 1'b0; t_rdy = 1'b0;
        @(negedge clk);
        chk("to_err_sticky", t_err, 1);

        // engine busy in IDLE
        do_reset();
        m_lat = 5;
        m_force = 1'b1;
        x0 = 10'h011; y0 = 8'h22; req0 = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen |= ack0 | ack1 | eng_start;
        end
        chk("busy_no_grant", seen, 0);
        m_force = 1'b0;
        @(negedge clk);
        chk("busy_ack0_next", {ack0, eng_start}, 2'b11);
        req0 = 1'b0;
        wait_done(20, ok);
        chk("busy_done_timeout", ok, 1);
        chk("busy_res0", res0, 10'h033);

        // abort during WAIT, no reset beforehand so res0 is nonzero
        @(negedge clk);
        m_lat = 20;
        x0 = 10'h0AA; y0 = 8'h11; req0 = 1'b1;
        wait_ack(10, ok);
        chk("abort_ack_timeout", ok, 1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("abort_async_zero", all_out, 64'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= done0 | done1;
        end
        rst = 1'b1;
        chk("abort_no_done", seen, 0);
        x0 = 10'h0C3; y0 = 8'h22; req0 = 1'b1;
        wait_ack(40, ok);
        chk("abort_regrant", {ok, ack0}, 2'b11);
        req0 = 1'b0;
        wait_done(40, ok);
        chk("abort_done_timeout", ok, 1);
        chk("abort_res0", res0, 10'h0E5);
        chk("abort_res1", res1, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // pulse outputs must never stay high two cycles in a row
    logic prev_pulse_valid = 1'b0;
    logic [4:0] prev_pulse = '0;
    always @(negedge clk) begin
        if (rst && prev_pulse_valid && |(prev_pulse & {eng_start, ack0, ack1, done0, done1}))
            chk("pulse_two_cycles", {prev_pulse, eng_start, ack0, ack1, done0, done1}, 10'd0);
        prev_pulse       <= {eng_start, ack0, ack1, done0, done1};
        prev_pulse_valid <= rst;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/cosine_arbiter.md
COSINE_ARBITER -- requirements
Module: cosine_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles allowed for an engine result (legal range 1..65535).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  in  1  level request from requester 0 / 1, held until the matching ack.
REQ-005 x0 / x1  in  10  operand x of requester 0 / 1.
REQ-006 y0 / y1  in  8  operand y of requester 0 / 1.
REQ-007 ack0 / ack1  out  1  one-cycle pulse: operands of requester 0 / 1 captured.
REQ-008 done0 / done1  out  1  one-cycle pulse: res0 / res1 updated.
REQ-009 res0 / res1  out  10  last result for requester 0 / 1, {intpart[1:0], fractpart[7:0]}.
REQ-010 eng_start  out  1  start pulse to the shared cosine engine.
REQ-011 eng_x  out  10 and eng_y  out  8  registered operands to the engine.
REQ-012 eng_ready  in  1  engine idle/result-valid flag.
REQ-013 eng_result  in  10  engine result {intpart, fractpart}.
REQ-014 err  out  1  sticky timeout flag.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LAUNCH, HOLD and WAIT.
REQ-016 IDLE: with eng_ready=1 and at least one req, the FSM SHALL select an owner, latch that owner's x/y into eng_x/eng_y at the edge, and go to LAUNCH.
REQ-017 IDLE with eng_ready=0 SHALL grant nothing and SHALL remain in IDLE.
REQ-018 Owner selection: with a single req, that requester SHALL be selected; with both reqs, the requester not served last SHALL be selected; after reset, requester 0 SHALL win the first tie.
REQ-019 LAUNCH: eng_start=1 and ack<owner>=1 for exactly this one cycle, then the FSM SHALL go to HOLD.
REQ-020 HOLD: eng_ready SHALL be ignored for this one cycle (engine drop latency), the timeout counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-021 WAIT with eng_ready=1: at the edge, eng_result SHALL be captured into res<owner>, done<owner> SHALL be 1 for the following cycle, the last-served pointer SHALL be set to the owner, and the FSM SHALL go to IDLE.
REQ-022 A new grant SHALL be allowed in the same IDLE cycle in which done is high.
REQ-023 WAIT with eng_ready=0: the 16-bit counter SHALL increment; on the TIMEOUT-th consecutive such cycle the block SHALL set err=1, assert no done, leave res unchanged, set the last-served pointer to the owner, and go to IDLE.
REQ-024 The res output of the non-owner SHALL never change.
REQ-025 eng_x/eng_y SHALL be held stable from LAUNCH until the next grant.
REQ-026 A req deasserted before its ack SHALL be treated as withdrawn; a req still high in the cycle after its ack SHALL be treated as a new request.
REQ-027 eng_start, ack* and done* SHALL never be high for two consecutive cycles.
REQ-028 err SHALL clear only on reset.

Reset
REQ-029 While rst=0, the block SHALL drive: state IDLE, eng_start=0, ack0=ack1=0, done0=done1=0, res0=res1=0, eng_x=0, eng_y=0, err=0, counter=0, and the last-served pointer set to 1 (requester 0 preferred).
REQ-030 Reset asserted mid-operation SHALL abort immediately without any done; the engine is not reset by this block.

Verification
REQ-031 Reset: rst=0 with random inputs -> all outputs 0; after release, no ack without a req.
REQ-032 Single request: req0=1, x0=10'h100, y0=8'h40; the engine model drops ready after start and returns 10'h2A5 after 20 cycles -> ack0 and eng_start in the same single cycle, eng_x=10'h100, eng_y=8'h40, one done0, res0=10'h2A5, res1=0.
REQ-033 Contention: req0 and req1 re-raised continuously, engine latency 5 -> grant order 0,1,0,1; each done goes to the correct requester with its own result.
REQ-034 Timeout: TIMEOUT=16, eng_ready stuck 0 after start -> err=1 exactly 16 WAIT cycles after HOLD, no done, and a subsequent req1 is granted once eng_ready=1.
REQ-035 Engine busy: eng_ready=0 in IDLE with req0=1 -> no ack/eng_start until eng_ready=1, then ack0 on the next cycle.
REQ-036 Abort: rst pulsed low during WAIT -> outputs zero asynchronously, no done; after release, req0 completes normally with res0 equal to the engine result.
